uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 115 +++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between a UART receiver and the host: first-word fall-through,
// parity tag per byte, sticky overrun, underrun pulse and hysteretic RTS flow control.
module uart_rx_fifo #(
  parameter int DEPTH      = 16,
  parameter int RTS_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     parity_error,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     ovr_clr,
  output logic [7:0]               rd_data,
  output logic                     rd_perr,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     underrun,
  output logic                     rts_n
);

  localparam int DATA_W = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] RTS_HI   = CW'(RTS_THRESH);
  localparam logic [CW-1:0] RTS_LO   = (RTS_THRESH < 2) ? '0 : CW'(RTS_THRESH - 2);

  logic [DATA_W:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [DATA_W:0]  head;

  logic             wr_ok;
  logic             rd_ok;
  logic             ovr_set;
  logic             und_nxt;
  logic [CW-1:0]    count_nxt;
  logic             rts_nxt;

  assign empty = (count == '0);
  assign full  = (count == FULL_LVL);

  // Head entry is forced to zero while empty so stale/unwritten storage never leaks out.
  assign head               = mem[rd_ptr];
  assign {rd_perr, rd_data} = empty ? '0 : head;

  always_comb begin
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    ovr_set   = 1'b0;
    und_nxt   = 1'b0;
    count_nxt = count;
    rts_nxt   = rts_n;

    if (!flush) begin
      rd_ok   = rd_en && !empty;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      wr_ok   = rx_done && (!full || rd_en);
      ovr_set = rx_done && full && !rd_en;
      und_nxt = rd_en && empty;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    if (flush) begin
      count_nxt = '0;
    end

    if (count_nxt >= RTS_HI) begin
      rts_nxt = 1'b1;
    end else if (count_nxt <= RTS_LO) begin
      rts_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      rts_n    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      end
      count    <= count_nxt;
      rts_n    <= rts_nxt;
      underrun <= und_nxt;
      // Set has priority over clear so a drop coinciding with ovr_clr is not lost.
      overrun  <= ovr_set | (overrun & ~ovr_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= {parity_error, rx_data};
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       parity_error = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       underrun;
  logic       rts_n;

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_und = 1'b0;
  logic       m_rts = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .RTS_THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .parity_error(parity_error), .rd_en(rd_en), .flush(flush), .ovr_clr(ovr_clr),
    .rd_data(rd_data), .rd_perr(rd_perr), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .underrun(underrun), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: applies one clock edge's worth of the FIFO rules to the queue.
  task automatic model_edge();
    int n;
    n = q.size();
    if (!rst_n) begin
      q.delete();
      m_ovr = 1'b0;
      m_und = 1'b0;
      m_rts = 1'b0;
      return;
    end
    if (flush) begin
      q.delete();
      m_und = 1'b0;
      if (ovr_clr) m_ovr = 1'b0;
    end else begin
      m_und = rd_en && (n == 0);
      if (rd_en && n > 0) void'(q.pop_front());
      if (rx_done && (n < DEPTH || rd_en)) q.push_back({parity_error, rx_data});
      if (rx_done && n == DEPTH && !rd_en) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
    if (q.size() >= THR) m_rts = 1'b1;
    else if (q.size() <= THR - 2) m_rts = 1'b0;
  endtask

  task automatic check_all();
    logic [8:0] h;
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overrun", overrun, m_ovr);
    chk("underrun", underrun, m_und);
    chk("rts_n", rts_n, m_rts);
    if (q.size() > 0) begin
      h = q[0];
      chk("rd_data", rd_data, h[7:0]);
      chk("rd_perr", rd_perr, h[8]);
    end
  endtask

  task automatic step(input logic d, input logic [7:0] b, input logic p, input logic r,
                      input logic f = 1'b0, input logic oc = 1'b0);
    rx_done = d; rx_data = b; parity_error = p; rd_en = r; flush = f; ovr_clr = oc;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 8'(base + i), 1'(i), 1'b0);
  endtask

  initial begin
    logic d, p, r, f, oc;
    int ph;

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_rts", rts_n, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // In-order read with parity tags
    step(1, 8'h41, 0, 0);
    step(1, 8'h42, 1, 0);
    step(1, 8'h43, 0, 0);
    chk("t36_cnt", count, 3);
    chk("t36_d0", {rd_perr, rd_data}, 9'h041);
    step(0, 0, 0, 1);
    chk("t36_d1", {rd_perr, rd_data}, 9'h142);
    step(0, 0, 0, 1);
    chk("t36_d2", {rd_perr, rd_data}, 9'h043);
    step(0, 0, 0, 1);
    chk("t36_empty", empty, 1);

    // Full and overrun
    fill(16, 8'h10);
    chk("t37_full", full, 1);
    step(1, 8'h99, 0, 0);
    chk("t37_ovr", overrun, 1);
    chk("t37_cnt", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("t37_pop", rd_data, 8'(8'h10 + i));
      step(0, 0, 0, 1);
    end
    chk("t37_empty", empty, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t37_clr", overrun, 0);

    // Simultaneous write and pop at full and at empty
    fill(16, 8'h20);
    step(1, 8'hA5, 1, 1);
    chk("t38_fcnt", count, 16);
    chk("t38_fovr", overrun, 0);
    step(0, 0, 0, 0, 1);
    step(1, 8'h5A, 0, 1);
    chk("t38_ecnt", count, 1);
    chk("t38_und1", underrun, 1);
    step(0, 0, 0, 0);
    chk("t38_und0", underrun, 0);
    step(0, 0, 0, 1);

    // RTS hysteresis
    fill(11, 8'h30);
    chk("t39_rts11", rts_n, 0);
    fill(1, 8'h3B);
    chk("t39_rts12", rts_n, 1);
    step(0, 0, 0, 1);
    chk("t39_rts_11", rts_n, 1);
    step(0, 0, 0, 1);
    chk("t39_rts_10", rts_n, 0);

    // Flush keeps overrun; reset clears everything
    step(0, 0, 0, 0, 1);
    fill(16, 8'h40);
    step(1, 8'hEE, 0, 0);
    step(0, 0, 0, 0, 1);
    fill(7, 8'h50);
    chk("t40_cnt7", count, 7);
    step(0, 0, 0, 0, 1);
    chk("t40_fcnt", count, 0);
    chk("t40_fempty", empty, 1);
    chk("t40_fovr", overrun, 1);
    fill(5, 8'h60);
    rst_n = 1'b0;
    step(1, 8'hFF, 1, 1);
    chk("t40_rcnt", count, 0);
    chk("t40_rovr", overrun, 0);
    chk("t40_rempty", empty, 1);
    rst_n = 1'b1;
    step(1, 8'h77, 1, 0);
    chk("t40_first", {rd_perr, rd_data}, 9'h177);
    step(0, 0, 0, 1);

    // Wrap-around with random data
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'($urandom), (i % 3) != 0);
    end
    while (!empty && total < 100000) step(0, 0, 0, 1);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 400; i++) begin
      ph = (i / 40) % 2;
      d  = $urandom_range(99, 0) < (ph != 0 ? 75 : 30);
      r  = $urandom_range(99, 0) < (ph != 0 ? 30 : 70);
      f  = $urandom_range(199, 0) == 0;
      oc = $urandom_range(99, 0) < 5;
      p  = 1'($urandom);
      step(d, 8'($urandom), p, r, f, oc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
